// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: turns lw/st into a req/ack bus
// transaction, holds the pipeline while it is in flight and returns formatted load data.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cmd_inM,
  input  logic [1:0]        size_inM,
  input  logic              uns_inM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_out,
  output logic              done_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Last counter value before abort; the counter starts at 0 on the first BUSY cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;

  logic        w_mem_cmd;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [DATA_W-1:0] w_wdata;

  function automatic logic [DATA_W-1:0] fmt_load(
    input logic [DATA_W-1:0] rdata,
    input logic [1:0]        off,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [DATA_W-1:0] lane;
    logic [7:0]        b;
    logic [15:0]       h;
    lane = rdata >> {off, 3'b000};
    b    = lane[7:0];
    h    = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   fmt_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   fmt_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: fmt_load = rdata;
    endcase
  endfunction

  assign w_mem_cmd = cmd_inM[1];
  assign w_misal   = ((size_inM == 2'b01) && addrM[0]) ||
                     (size_inM[1] && (addrM[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdataM;
    case (size_inM)
      2'b00: begin
        w_be    = 4'b0001 << addrM[1:0];
        w_wdata = {4{wdataM[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addrM[1:0];
        w_wdata = {2{wdataM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdataM;
      end
    endcase
  end

  // The pipeline is held from the cycle the command is seen until the DONE cycle.
  assign stall_out = !reset &&
                     (((r_state == S_IDLE) && w_mem_cmd) || (r_state == S_BUSY));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'h0;
      bus_wdata <= '0;
      done_out  <= 1'b0;
      rdata_out <= '0;
      err_out   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done_out <= 1'b0;
          err_out  <= 1'b0;
          if (w_mem_cmd) begin
            if (w_misal) begin
              rdata_out <= '0;
              err_out   <= 1'b1;
              done_out  <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= ~cmd_inM[0];
              bus_addr  <= {addrM[ADDR_W-1:2], 2'b00};
              bus_be    <= w_be;
              bus_wdata <= w_wdata;
              r_off     <= addrM[1:0];
              r_size    <= size_inM;
              r_uns     <= uns_inM;
              r_cnt     <= 8'h0;
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // An ack in the timeout cycle still completes the access cleanly.
          if (bus_ack) begin
            bus_req   <= 1'b0;
            rdata_out <= bus_we ? '0 : fmt_load(bus_rdata, r_off, r_size, r_uns);
            err_out   <= 1'b0;
            done_out  <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_cnt == TO_LAST) begin
            bus_req   <= 1'b0;
            rdata_out <= '0;
            err_out   <= 1'b1;
            done_out  <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'h1;
          end
        end
        S_DONE: begin
          done_out <= 1'b0;
          err_out  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          bus_req  <= 1'b0;
          done_out <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expected bus
// requests and completions; monitors pop and compare when the DUT presents them.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_inM;
  logic [1:0]  size_inM;
  logic        uns_inM;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_out;
  logic        done_out;
  logic [31:0] rdata_out;
  logic        err_out;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .cmd_inM(cmd_inM), .size_inM(size_inM),
    .uns_inM(uns_inM), .addrM(addrM), .wdataM(wdataM), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_out(stall_out),
    .done_out(done_out), .rdata_out(rdata_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  bit    prev_req = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Bus monitor: every new request must match the next expected one.
  always @(negedge clk) begin
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_bus_req", 32'(bus_req), 32'd0);
      end else begin
        bus_t e;
        e = bus_q.pop_front();
        chk("bus_we",    32'(bus_we), 32'(e.we));
        chk("bus_addr",  bus_addr,    e.addr);
        chk("bus_be",    32'(bus_be), 32'(e.be));
        chk("bus_wdata", bus_wdata,   e.wd);
      end
    end
    prev_req = bus_req;
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (done_out) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'(done_out), 32'd0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("rdata_out", rdata_out,    d.rdata);
        chk("err_out",   32'(err_out), 32'(d.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issues one command in the current cycle, acks in BUSY cycle ack_at (0 = never),
  // and checks stall/done timing against the hand-computed done cycle.
  task automatic access(input string nm, input logic [1:0] c, input logic [1:0] s,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd, input int exp_done);
    bit seen;
    seen     = 1'b0;
    cmd_inM  = c;
    size_inM = s;
    uns_inM  = u;
    addrM    = a;
    wdataM   = wd;
    bus_ack  = 1'b0;
    #1;
    chk({nm, "_stall_c0"}, 32'(stall_out), 32'd1);
    for (int i = 1; i <= 20 && !seen; i++) begin
      cyc();
      bus_ack   = (i == ack_at);
      bus_rdata = rd;
      #1;
      if (done_out) begin
        seen = 1'b1;
        chk({nm, "_done_cycle"}, 32'(i), 32'(exp_done));
        chk({nm, "_stall_done"}, 32'(stall_out), 32'd0);
        cmd_inM = 2'b00;
        bus_ack = 1'b0;
      end else if (stall_out !== 1'b1) begin
        chk({nm, "_stall_busy"}, 32'(stall_out), 32'd1);
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 32'(seen), 32'd1);
    cyc();
    chk({nm, "_done_pulse1"}, 32'(done_out), 32'd0);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_inM = 2'b11; size_inM = 2'b10; uns_inM = 1'b0;
    addrM = 32'h100; wdataM = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    cyc(); cyc();
    #1;
    chk("rst_stall",     32'(stall_out), 32'd0);
    chk("rst_bus_req",   32'(bus_req),   32'd0);
    chk("rst_bus_we",    32'(bus_we),    32'd0);
    chk("rst_bus_addr",  bus_addr,       32'd0);
    chk("rst_bus_be",    32'(bus_be),    32'd0);
    chk("rst_bus_wdata", bus_wdata,      32'd0);
    chk("rst_done",      32'(done_out),  32'd0);
    chk("rst_rdata",     rdata_out,      32'd0);
    chk("rst_err",       32'(err_out),   32'd0);
    cmd_inM = 2'b00;
    cyc();
    reset = 1'b0;
    cyc();

    // lw word 0x100, ack in cycle 3
    bus_q.push_back('{1'b0, 32'h100, 4'b1111, 32'h0});
    done_q.push_back('{32'hDEADBEEF, 1'b0});
    access("lw", 2'b11, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4);

    // lb / lbu at 0x203
    bus_q.push_back('{1'b0, 32'h200, 4'b1000, 32'h0});
    done_q.push_back('{32'hFFFFFF80, 1'b0});
    access("lb", 2'b11, 2'b00, 1'b0, 32'h203, 32'h0, 1, 32'h80000000, 2);
    bus_q.push_back('{1'b0, 32'h200, 4'b1000, 32'h0});
    done_q.push_back('{32'h00000080, 1'b0});
    access("lbu", 2'b11, 2'b00, 1'b1, 32'h203, 32'h0, 1, 32'h80000000, 2);

    // sh at 0x202
    bus_q.push_back('{1'b1, 32'h200, 4'b1100, 32'hABCDABCD});
    done_q.push_back('{32'h0, 1'b0});
    access("sh", 2'b10, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 2, 32'hFFFFFFFF, 3);

    // lh / lhu lane selection
    bus_q.push_back('{1'b0, 32'h204, 4'b1100, 32'h0});
    done_q.push_back('{32'hFFFF8001, 1'b0});
    access("lh", 2'b11, 2'b01, 1'b0, 32'h206, 32'h0, 1, 32'h80017FFF, 2);
    bus_q.push_back('{1'b0, 32'h204, 4'b0011, 32'h0});
    done_q.push_back('{32'h00007FFF, 1'b0});
    access("lhu", 2'b11, 2'b01, 1'b1, 32'h204, 32'h0, 1, 32'h80017FFF, 2);

    // sb at 0x101, sw at 0x0C
    bus_q.push_back('{1'b1, 32'h100, 4'b0010, 32'h55555555});
    done_q.push_back('{32'h0, 1'b0});
    access("sb", 2'b10, 2'b00, 1'b0, 32'h101, 32'h00000055, 1, 32'h0, 2);
    bus_q.push_back('{1'b1, 32'h00C, 4'b1111, 32'hCAFEF00D});
    done_q.push_back('{32'h0, 1'b0});
    access("sw", 2'b10, 2'b10, 1'b0, 32'h00C, 32'hCAFEF00D, 2, 32'h0, 3);

    // reserved size behaves as word
    bus_q.push_back('{1'b0, 32'h500, 4'b1111, 32'h0});
    done_q.push_back('{32'h89ABCDEF, 1'b0});
    access("lw_rsv", 2'b11, 2'b11, 1'b0, 32'h500, 32'h0, 2, 32'h89ABCDEF, 3);

    // misaligned: no bus request, one-cycle stall, err
    done_q.push_back('{32'h0, 1'b1});
    access("lw_mis", 2'b11, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1);
    done_q.push_back('{32'h0, 1'b1});
    access("sh_mis", 2'b10, 2'b01, 1'b0, 32'h201, 32'h1111, 0, 32'h0, 1);

    // timeout after 4 BUSY cycles, then a spurious ack in IDLE
    bus_q.push_back('{1'b0, 32'h400, 4'b1111, 32'h0});
    done_q.push_back('{32'h0, 1'b1});
    access("lw_to", 2'b11, 2'b10, 1'b0, 32'h400, 32'h0, 0, 32'h0, 5);
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    #1;
    chk("spurious_ack_done", 32'(done_out), 32'd0);
    chk("spurious_ack_req",  32'(bus_req),  32'd0);

    // ack coincident with timeout wins
    bus_q.push_back('{1'b0, 32'h404, 4'b1111, 32'h0});
    done_q.push_back('{32'h13572468, 1'b0});
    access("lw_tie", 2'b11, 2'b10, 1'b0, 32'h404, 32'h0, 4, 32'h13572468, 5);

    // jmp / other never stall or touch the bus
    for (int i = 0; i < 3; i++) begin
      cmd_inM = (i == 1) ? 2'b00 : 2'b01;
      #1;
      chk("jmp_stall", 32'(stall_out), 32'd0);
      cyc();
    end
    cmd_inM = 2'b00;

    // reset during the second BUSY cycle
    bus_q.push_back('{1'b0, 32'h300, 4'b1111, 32'h0});
    cmd_inM = 2'b11; size_inM = 2'b10; uns_inM = 1'b0; addrM = 32'h300;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rstbusy_req_before", 32'(bus_req),   32'd1);
    chk("rstbusy_stall_rst",  32'(stall_out), 32'd0);
    cyc();
    reset   = 1'b0;
    cmd_inM = 2'b00;
    #1;
    chk("rstbusy_req",   32'(bus_req),   32'd0);
    chk("rstbusy_stall", 32'(stall_out), 32'd0);
    chk("rstbusy_done",  32'(done_out),  32'd0);
    cyc();
    #1;
    chk("rstbusy_done2", 32'(done_out),  32'd0);
    chk("rstbusy_idle",  32'(stall_out), 32'd0);

    cyc(); cyc();
    chk("bus_q_drained",  32'(bus_q.size()),  32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Data-memory access controller for the M stage. It turns lw/st commands into a request/acknowledge transaction on the data bus, and it generates the stall and done indications that the hazard unit consumes. While an access is in flight it holds the pipeline. It returns aligned, extended load data and flags errors.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (fixed 32 for byte-lane logic)
TIMEOUT, 255, max cycles waiting for bus_ack before abort (8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_inM  in  2  M-stage command: 11 lw, 10 st, 01 jmp, 00 other
size_inM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
uns_inM  in  1  1 = zero-extend load, 0 = sign-extend
addrM  in  ADDR_W  effective address
wdataM  in  DATA_W  store data, right-aligned
bus_req  out  1  request valid
bus_we  out  1  1 store, 0 load
bus_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
bus_be  out  4  byte enables
bus_wdata  out  DATA_W  store data shifted to byte lanes
bus_ack  in  1  responder completion, one-cycle pulse
bus_rdata  in  DATA_W  load data, valid with bus_ack
stall_out  out  1  hold pipeline (to hazard unit stall_in)
done_out  out  1  access complete pulse (to hazard unit done_in)
rdata_out  out  DATA_W  formatted load result, valid while done_out
err_out  out  1  misaligned or timeout, valid while done_out

Behaviour:
- Reset state: IDLE. bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, done_out=0, rdata_out=0, err_out=0, timeout counter=0.
- stall_out is combinational: 1 in IDLE when cmd_inM is lw/st; 1 in BUSY; 0 in DONE; 0 during reset.
- States:
  - IDLE:
    - cmd lw/st and aligned: latch we, addr, be, shifted wdata, offset, size, uns; bus_req=1 from next cycle; go to BUSY.
    - cmd lw/st and misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus request; go to DONE with err=1 and rdata=0.
    - Any other cmd: stay in IDLE.
  - BUSY:
    - Bus outputs are held stable; the counter increments every cycle.
    - bus_ack=1: capture bus_rdata; drop bus_req at the next edge; go to DONE with err=0.
    - Counter reaches TIMEOUT with no ack: drop bus_req; go to DONE with err=1 and rdata=0.
  - DONE: lasts exactly 1 cycle with done_out=1, then returns to IDLE. It ignores cmd_inM, because that is still the same instruction being released. The next instruction is evaluated in IDLE on the following cycle.
- Latency:
  - Command seen in cycle 0 → bus_req=1 in cycle 1.
  - bus_ack in cycle k → done_out=1 and stall_out=0 in cycle k+1.
  - Minimum total stall is 2 cycles (ack in cycle 1). A misaligned access stalls 1 cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - bus_wdata = wdataM replicated to the lane (byte ×4, half ×2).
- Load formatting: select the lane by the latched offset, then sign- or zero-extend per uns. Stores return rdata_out=0.
- Boundary cases:
  - bus_ack in IDLE or DONE: ignored.
  - bus_ack arriving in the same cycle the counter hits TIMEOUT: the ack wins, err=0.
  - Reset asserted mid-BUSY: IDLE and bus_req=0 at that edge, with no done_out. The responder tolerates an abandoned request.
  - jmp/other commands never touch the bus.

Test Plan:
- lw word at 0x100, bus_ack in cycle 3 returning 0xDEADBEEF → bus_req cycles 1–3, bus_addr=0x100, bus_be=1111, bus_we=0; done_out and rdata_out=0xDEADBEEF in cycle 4; stall_out 1 in cycles 0–3, 0 in cycle 4.
- lb signed at 0x203, bus_rdata=0x80000000 → bus_be=1000, rdata_out=0xFFFFFF80. lbu with the same data → rdata_out=0x00000080.
- sh at 0x202 with wdataM=0x1234ABCD → bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200; done_out=1, err_out=0.
- lw at 0x101 → no bus_req; done_out=1 with err_out=1 in cycle 1; stall_out 1 in cycle 0 only.
- lw with bus_ack never asserted, TIMEOUT=4 → bus_req drops after 4 BUSY cycles; done_out=1, err_out=1, rdata_out=0. A spurious bus_ack one cycle later is ignored.
- reset asserted in the 2nd BUSY cycle → bus_req=0 and stall_out=0 the following cycle, no done_out pulse, state IDLE.
